// File: rtl/rv32i_memory.sv
// -----------------------------------------------------------------------------
// rv32i_memory
//
// Memory-access pipeline stage that sits directly after execute. Non-memory
// instructions pass through with one cycle of latency. Loads and stores are
// issued as one outstanding request on a req/ack data bus; the stage holds the
// upstream pipeline until the access completes or times out. Load data is
// lane-selected and sign/zero extended before writeback.
//
// Parameters
//   TIMEOUT_CYCLES : BUS cycles without dmem_ack before abort (0 = never)
//   TMO_WIDTH      : timeout counter width, 2**TMO_WIDTH > TIMEOUT_CYCLES
//
// Optional build macro
//   MEM_MISALIGN_TRAP_EN : misaligned half/word accesses issue no bus request
//                          and pulse memory_misaligned with the faulting
//                          address on memory_wb_data. When undefined the port
//                          is absent and low address bits beyond lane select
//                          are ignored.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   execute_*                 instruction presented by the execute stage
//   memory_flush              discard the stage contents
//   memory_stall              hold upstream stages (combinational)
//   dmem_req/we/addr/be/wdata registered bus request fields
//   dmem_ack, dmem_rdata      bus completion and read data
//   memory_valid/rd/reg_write registered writeback control
//   memory_wb_data            registered writeback data
//   memory_bus_error          one-cycle pulse on bus timeout
//   memory_misaligned         one-cycle misalignment pulse (optional)
// -----------------------------------------------------------------------------
module rv32i_memory #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TMO_WIDTH      = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        execute_valid,
   input  logic        execute_load,
   input  logic        execute_store,
   input  logic [2:0]  execute_funct3,
   input  logic [4:0]  execute_rd,
   input  logic        execute_reg_write,
   input  logic [31:0] execute_alu_result,
   input  logic [31:0] execute_rs2_data,
   input  logic        memory_flush,
   output logic        memory_stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        memory_valid,
   output logic [4:0]  memory_rd,
   output logic        memory_reg_write,
   output logic [31:0] memory_wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        memory_bus_error,
   output logic        memory_misaligned
`else
   output logic        memory_bus_error
`endif
);

   typedef enum logic {
      S_IDLE,
      S_BUS
   } state_t;

   localparam int unsigned TMO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_LAST_INT);

   // Lane select and sign/zero extension of returned load data.
   function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  load_format = {{24{b[7]}}, b};
         3'b001:  load_format = {{16{h[15]}}, h};
         3'b100:  load_format = {24'd0, b};
         3'b101:  load_format = {16'd0, h};
         default: load_format = rdata;   // 010 plus reserved 011/110/111
      endcase
   endfunction

   state_t                 state_q, state_d;
   logic                   req_q, req_d;
   logic                   we_q, we_d;
   logic [31:0]            addr_q, addr_d;
   logic [3:0]             be_q, be_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [2:0]             funct3_q, funct3_d;
   logic [4:0]             pend_rd_q, pend_rd_d;
   logic                   pend_rw_q, pend_rw_d;
   logic                   flush_q, flush_d;
   logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
   logic                   valid_q, valid_d;
   logic [4:0]             wb_rd_q, wb_rd_d;
   logic                   wb_rw_q, wb_rw_d;
   logic [31:0]            wb_data_q, wb_data_d;
   logic                   err_q, err_d;
`ifdef MEM_MISALIGN_TRAP_EN
   logic                   mis_q, mis_d;
`endif

   logic                   mem_op;
   logic [1:0]             off;
   logic [1:0]             size;
   logic                   misaligned;
   logic                   tmo_hit;
   logic [3:0]             be_calc;
   logic [31:0]            wdata_calc;

   assign mem_op = execute_valid & (execute_load | execute_store);
   assign off    = execute_alu_result[1:0];
   // funct3[1:0]: 00 byte, 01 half, anything else is a word access.
   assign size   = execute_funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = mem_op & (((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

   always_comb begin
      case (size)
         2'b00: begin
            be_calc    = 4'b0001 << off;
            wdata_calc = {4{execute_rs2_data[7:0]}};
         end
         2'b01: begin
            be_calc    = off[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{execute_rs2_data[15:0]}};
         end
         default: begin
            be_calc    = 4'b1111;
            wdata_calc = execute_rs2_data;
         end
      endcase
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      funct3_d     = funct3_q;
      pend_rd_d    = pend_rd_q;
      pend_rw_d    = pend_rw_q;
      flush_d      = flush_q;
      tmo_d        = tmo_q;
      valid_d      = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_rw_d      = 1'b0;
      wb_data_d    = wb_data_q;
      err_d        = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_d        = 1'b0;
`endif
      memory_stall = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (memory_flush) begin
               // Flush wins over everything presented this cycle.
            end else if (misaligned) begin
`ifdef MEM_MISALIGN_TRAP_EN
               mis_d = 1'b1;
`endif
               wb_rd_d   = execute_rd;
               wb_data_d = execute_alu_result;
            end else if (mem_op) begin
               memory_stall = 1'b1;
               state_d      = S_BUS;
               req_d        = 1'b1;
               we_d         = execute_store;
               addr_d       = execute_alu_result;
               be_d         = be_calc;
               wdata_d      = wdata_calc;
               funct3_d     = execute_funct3;
               pend_rd_d    = execute_rd;
               pend_rw_d    = execute_load & execute_reg_write & (execute_rd != 5'd0);
               flush_d      = 1'b0;
               tmo_d        = '0;
            end else if (execute_valid) begin
               valid_d   = 1'b1;
               wb_rd_d   = execute_rd;
               wb_rw_d   = execute_reg_write & (execute_rd != 5'd0);
               wb_data_d = execute_alu_result;
            end
         end

         S_BUS: begin
            if (dmem_ack) begin
               // Ack beats a timeout reached in the same cycle.
               state_d   = S_IDLE;
               req_d     = 1'b0;
               valid_d   = ~(flush_q | memory_flush);
               wb_rd_d   = pend_rd_q;
               wb_rw_d   = pend_rw_q & ~(flush_q | memory_flush);
               wb_data_d = we_q ? addr_q : load_format(funct3_q, addr_q[1:0], dmem_rdata);
               flush_d   = 1'b0;
               tmo_d     = '0;
            end else if (tmo_hit) begin
               // Abort: stall is released so the faulting op leaves execute.
               state_d = S_IDLE;
               req_d   = 1'b0;
               err_d   = 1'b1;
               flush_d = 1'b0;
               tmo_d   = '0;
            end else begin
               memory_stall = 1'b1;
               tmo_d        = tmo_q + TMO_WIDTH'(1);
               flush_d      = flush_q | memory_flush;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         funct3_q  <= '0;
         pend_rd_q <= '0;
         pend_rw_q <= 1'b0;
         flush_q   <= 1'b0;
         tmo_q     <= '0;
         valid_q   <= 1'b0;
         wb_rd_q   <= '0;
         wb_rw_q   <= 1'b0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         funct3_q  <= funct3_d;
         pend_rd_q <= pend_rd_d;
         pend_rw_q <= pend_rw_d;
         flush_q   <= flush_d;
         tmo_q     <= tmo_d;
         valid_q   <= valid_d;
         wb_rd_q   <= wb_rd_d;
         wb_rw_q   <= wb_rw_d;
         wb_data_q <= wb_data_d;
         err_q     <= err_d;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q     <= mis_d;
`endif
      end
   end

   assign dmem_req          = req_q;
   assign dmem_we           = we_q;
   assign dmem_addr         = {addr_q[31:2], 2'b00};
   assign dmem_be           = be_q;
   assign dmem_wdata        = wdata_q;
   assign memory_valid      = valid_q;
   assign memory_rd         = wb_rd_q;
   assign memory_reg_write  = wb_rw_q;
   assign memory_wb_data    = wb_data_q;
   assign memory_bus_error  = err_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign memory_misaligned = mis_q;
`endif

endmodule

// File: doc/rv32i_memory.md
Name: rv32i_memory

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the execute results (ALU result as address/data, rs2 as store data, load/store control).
- Drives a single-outstanding request/acknowledge data bus and formats load data (byte-lane select, sign/zero extension).
- Produces registered writeback results, a stall to hold upstream stages while a bus access is pending, and a bus-timeout error pulse.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUS without dmem_ack before abort; 0 disables timeout.
- TMO_WIDTH, 8: width of the timeout counter; must satisfy 2^TMO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- execute_valid  input  1  execute stage holds a valid instruction
- execute_load  input  1  instruction is a load
- execute_store  input  1  instruction is a store
- execute_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- execute_rd  input  5  destination register
- execute_reg_write  input  1  instruction writes rd
- execute_alu_result  input  32  effective address (mem ops) or result (others)
- execute_rs2_data  input  32  store data
- memory_flush  input  1  discard stage contents
- memory_stall  output  1  hold upstream stages (combinational)
- dmem_req  output  1  bus request, registered
- dmem_we  output  1  write enable
- dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_ack  input  1  bus completion, one cycle
- dmem_rdata  input  32  read data, valid with dmem_ack
- memory_valid  output  1  writeback result valid
- memory_rd  output  5  writeback register
- memory_reg_write  output  1  writeback enable (0 for stores, rd==0 forced 0)
- memory_wb_data  output  32  writeback data
- memory_bus_error  output  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; every registered output 0; timeout counter 0.
- mem_op = execute_valid & (execute_load | execute_store).
- FSM has two states: IDLE and BUS.
- IDLE, non-mem valid op:
  - Next cycle memory_valid=1, wb_data=alu_result, rd/reg_write passed through.
  - Latency 1; no stall.
- IDLE, mem_op:
  - memory_stall=1.
  - Register address, be, wdata, we, funct3, addr[1:0], rd; dmem_req=1 next cycle; go to BUS.
  - memory_valid=0 that cycle.
- BUS:
  - dmem_req and the bus fields are held stable until dmem_ack.
  - memory_stall = ~dmem_ack.
- BUS, dmem_ack:
  - dmem_req drops next cycle; memory_valid=1 next cycle; return to IDLE.
  - Load: wb_data = extracted/extended rdata. Store: reg_write=0.
  - Minimum memory-op latency 2 cycles (ack in first BUS cycle).
- Byte lanes (off = addr[1:0]):
  - B: be = 0001<<off.
  - H: be = 0011<<(off[1]*2).
  - W: be = 1111.
  - SB wdata = {4{rs2[7:0]}}; SH wdata = {2{rs2[15:0]}}; SW wdata = rs2.
- Load extraction:
  - Byte/half selected by off / off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- funct3 values 011, 110, 111 are treated as word access.
- Timeout:
  - Counter increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop req, memory_bus_error=1 for one cycle, memory_valid=0, stall released, return to IDLE, counter cleared.
  - Ack in the same cycle the counter reaches terminal count: treated as ack; no error.
- Flush:
  - In IDLE: input discarded, memory_valid=0, no request issued; flush has priority over mem_op.
  - In BUS: bus transaction is not aborted; completes normally, but memory_valid/reg_write suppressed on completion (flush remembered in a sticky bit until ack).
- Reset asserted mid-BUS: immediate return to IDLE, dmem_req=0; a later stray ack is ignored.
- Ack while in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned half (off[0]=1) or word (off!=0) access issues no bus request.
  - Output memory_misaligned (1 bit, registered) pulses for one cycle with memory_wb_data = faulting address, memory_valid=0, no stall.
- Undefined:
  - Port absent.
  - Low address bits beyond lane select are ignored (half uses off[1], word forces aligned).

Test Plan:
- ADD result 0x1234 with reg_write, rd=5 -> next cycle memory_valid=1, rd=5, wb_data=0x00001234, memory_stall=0.
- LB addr 0x103, ack after 3 cycles with rdata 0x80FFFFFF -> be=1000, addr=0x100, stall for 4 cycles, wb_data=0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x202, rs2=0xDEADBEEF -> dmem_we=1, be=1100, wdata=0xBEEFBEEF; on ack memory_reg_write=0.
- TIMEOUT_CYCLES=4, no ack -> req high 4 cycles, memory_bus_error pulse, state IDLE, stall low, memory_valid=0.
- Flush asserted in second BUS cycle of LW -> req held until ack, memory_valid stays 0; next ADD passes normally.
- MEM_MISALIGN_TRAP_EN, LW addr 0x301 -> no dmem_req, memory_misaligned=1, wb_data=0x00000301.
